rob_banked: RTL
===============

# rob_banked

Parametrised, banked reorder buffer and successor of the fixed 4-bank ROB. It holds NBANK instruction slots per row, and dispatch writes one row per cycle. It takes NWB writeback ports, supports branch-mask kill with tail rollback and masks cleared on branch resolve, and detects exceptions at commit with a full flush. It sits between rename/dispatch and the free list/commit logic.

## Interface
- NBANK, 4: slots per row (power of 2, ≥2)
- WIDTH_BANK, 3: log2 of row count; SIZE = 2**WIDTH_BANK
- WIDTH_REG, 7: physical register index width
- WIDTH_BRM, 4: branch mask width (one bit per in-flight branch)
- NWB, 4: writeback ports
- WIDTH_TAG, derived: WIDTH_BANK + log2(NBANK); tag = {row, bank}
---
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_dis_we  in  1  dispatch one row
- i_dis_val  in  NBANK  per-slot valid
- i_dis_prd  in  NBANK*WIDTH_REG  destination physical regs
- i_dis_brmask  in  NBANK*WIDTH_BRM  per-slot branch dependency mask
- i_dis_pc  in  32  PC of bank-0 slot; slot b PC = pc + 4*b
- o_dis_ready  out  1  row free (not full)
- o_dis_tag  out  WIDTH_BANK  row that the next dispatch writes (tail)
- i_wb_en  in  NWB  writeback valid per port
- i_wb_tag  in  NWB*WIDTH_TAG  slot completed
- i_wb_exc  in  NWB  completion raised exception
- i_br_clr  in  WIDTH_BRM  resolved-correct branches; clear these bits in all masks
- i_kill_en  in  1  mispredict kill
- i_kill_mask  in  WIDTH_BRM  mispredicted branch bit(s)
- i_kill_row  in  WIDTH_BANK  row holding mispredicted branch
- o_com_en  out  1  head row retires this cycle
- o_com_val  out  NBANK  retiring slots that were valid
- o_com_prd  out  NBANK*WIDTH_REG  retiring destination regs
- o_exc  out  1  exception at head; flush follows
- o_exc_pc  out  32  PC of lowest-bank excepting slot

## Operation
- State: head and tail are WIDTH_BANK-bit binary row pointers with modulo-SIZE wrap. count runs 0..SIZE. Per row: pc[31:2]. Per slot: val, busy, exc, prd, brmask.
- o_dis_ready = (count != SIZE). Dispatch accepted when i_dis_we & o_dis_ready & ~i_kill_en & ~o_exc. It writes the tail row with val=i_dis_val, busy=i_dis_val, exc=0; tail+1, count+1.
- Writeback port p: if the addressed slot is val and busy, then busy←0 and exc←i_wb_exc[p]. Writebacks to invalid slots are ignored. Multiple ports to the same slot: OR of exc.
- Head ready = count≠0 and every slot in the head row has busy=0.
- Head ready with no val&exc slot: o_com_en=1, o_com_val=val bits, o_com_prd=prd. Then head+1, count−1, and the row's val is cleared. A row with all val=0 still retires, with o_com_val=0.
- Head ready with any val&exc slot: o_com_en=0 and o_exc=1. o_exc_pc = row pc + 4*(lowest excepting bank). Next edge flushes all state: head=tail=count=0, all val/busy=0.
- i_br_clr: every stored brmask &= ~i_br_clr.
- Kill: every slot with (brmask & i_kill_mask)≠0 gets val←0 and busy←0. Then tail←i_kill_row+1 and count←((i_kill_row−head) mod SIZE)+1. A dispatch in the same cycle is dropped.
- Priority per edge: reset > flush (o_exc) > kill > commit/dispatch/writeback/br_clr. Commit and kill in the same cycle: both apply, and count accounts for both (count−1 after rollback).
- Outputs o_com_*, o_exc, o_exc_pc and o_dis_ready are combinational from registered state only; there is no input-to-output path.

## Timing
- Reset: head=tail=count=0, all val/busy/exc=0. o_dis_ready=1, o_dis_tag=0, o_com_en=0, o_com_val=0, o_exc=0, o_exc_pc=0.
- Dispatch at edge N: o_dis_tag advances after N. A writeback is accepted from edge N+1 on.
- Writeback at edge N clears busy. If that completes the head row, o_com_en=1 in cycle N+1, and the row is freed at edge N+2.
- One row retires per cycle maximum. Full throughput is 1 dispatch + 1 commit per cycle with count unchanged.
- Full (count=SIZE): dispatch ignored. A simultaneous commit makes o_dis_ready=1 the next cycle.
- Wrap: tail and head roll from SIZE−1 to 0 without a bubble.
- Exception: o_exc is high one cycle. The flush takes effect at the next edge, and o_exc is 0 afterwards.

## Test plan
- Reset mid-stream with count=5: outputs return to reset values asynchronously; o_dis_ready=1, o_dis_tag=0.
- Dispatch 8 rows with NBANK=4 and WIDTH_BANK=3 -> o_dis_ready=0. Write back all 4 tags of row 0 -> o_com_en=1 and o_com_val=4'b1111 one cycle later, then o_dis_ready=1.
- Dispatch row 0 with val=4'b0101 and write back only banks 0 and 2 -> commit with o_com_val=4'b0101, and o_com_prd matches the dispatched regs.
- Row 0 pc=0x100, writeback of bank 2 with exc=1 -> o_exc=1 and o_exc_pc=0x108. The next cycle has count=0 and tail=0.
- Rows 0–4 dispatched, with rows 2–4 brmask=4'b0010. Kill with mask=4'b0010 and row=1 -> tail=2, count=2; the next dispatch gets tag 2.
- Wrap test: run 20 rows through with continuous dispatch and commit -> in-order o_com_prd, no lost rows, and count never exceeds 8.

Source files
------------

// File: rtl/rob_banked.sv
// Banked reorder buffer: one row dispatched and one row retired per cycle, with branch kill and exception flush.
// Commit is one cycle after the last writeback of the head row; dispatch stalls via o_dis_ready when all rows are in use.
module rob_banked #(
   parameter int NBANK      = 4,
   parameter int WIDTH_BANK = 3,
   parameter int WIDTH_REG  = 7,
   parameter int WIDTH_BRM  = 4,
   parameter int NWB        = 4,
   localparam int WIDTH_BK  = $clog2(NBANK),
   localparam int WIDTH_TAG = WIDTH_BANK + WIDTH_BK
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_dis_we,
   input  logic [NBANK-1:0]            i_dis_val,
   input  logic [NBANK*WIDTH_REG-1:0]  i_dis_prd,
   input  logic [NBANK*WIDTH_BRM-1:0]  i_dis_brmask,
   input  logic [31:0]                 i_dis_pc,
   output logic                        o_dis_ready,
   output logic [WIDTH_BANK-1:0]       o_dis_tag,
   input  logic [NWB-1:0]              i_wb_en,
   input  logic [NWB*WIDTH_TAG-1:0]    i_wb_tag,
   input  logic [NWB-1:0]              i_wb_exc,
   input  logic [WIDTH_BRM-1:0]        i_br_clr,
   input  logic                        i_kill_en,
   input  logic [WIDTH_BRM-1:0]        i_kill_mask,
   input  logic [WIDTH_BANK-1:0]       i_kill_row,
   output logic                        o_com_en,
   output logic [NBANK-1:0]            o_com_val,
   output logic [NBANK*WIDTH_REG-1:0]  o_com_prd,
   output logic                        o_exc,
   output logic [31:0]                 o_exc_pc
);
   localparam int SIZE = 2**WIDTH_BANK;

   logic [WIDTH_BANK-1:0] head_q, head_d, tail_q, tail_d;
   logic [WIDTH_BANK:0]   count_q, count_d;
   logic [29:0]           pc_q   [SIZE];
   logic [29:0]           pc_d   [SIZE];
   logic [NBANK-1:0]      val_q  [SIZE];
   logic [NBANK-1:0]      val_d  [SIZE];
   logic [NBANK-1:0]      busy_q [SIZE];
   logic [NBANK-1:0]      busy_d [SIZE];
   logic [NBANK-1:0]      exc_q  [SIZE];
   logic [NBANK-1:0]      exc_d  [SIZE];
   logic [WIDTH_REG-1:0]  prd_q  [SIZE][NBANK];
   logic [WIDTH_REG-1:0]  prd_d  [SIZE][NBANK];
   logic [WIDTH_BRM-1:0]  brm_q  [SIZE][NBANK];
   logic [WIDTH_BRM-1:0]  brm_d  [SIZE][NBANK];

   logic                  head_rdy, head_exc, com_en, dis_acc;
   logic [NBANK-1:0]      exc_vec;
   logic [WIDTH_BK-1:0]   exc_bank;
   logic [WIDTH_BANK-1:0] wb_row;
   logic [WIDTH_BK-1:0]   wb_bank;
   logic                  unused_pc_lsb;

   assign unused_pc_lsb = ^i_dis_pc[1:0];

   always_comb begin
      exc_vec  = val_q[head_q] & exc_q[head_q];
      head_rdy = (count_q != '0) && (busy_q[head_q] == '0);
      head_exc = head_rdy && (exc_vec != '0);
      com_en   = head_rdy && !head_exc;
      exc_bank = '0;
      for (int b = NBANK-1; b >= 0; b--) begin
         if (exc_vec[b]) exc_bank = WIDTH_BK'(b);
      end
   end

   assign o_dis_ready = (count_q != (WIDTH_BANK+1)'(SIZE));
   assign o_dis_tag   = tail_q;
   assign o_com_en    = com_en;
   assign o_com_val   = com_en ? val_q[head_q] : '0;
   assign o_exc       = head_exc;
   assign o_exc_pc    = head_exc ? {pc_q[head_q] + 30'(exc_bank), 2'b00} : '0;
   assign dis_acc     = i_dis_we && o_dis_ready && !i_kill_en && !head_exc;

   always_comb begin
      o_com_prd = '0;
      for (int b = 0; b < NBANK; b++) begin
         o_com_prd[b*WIDTH_REG +: WIDTH_REG] = com_en ? prd_q[head_q][b] : '0;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pc_d    = pc_q;
      val_d   = val_q;
      busy_d  = busy_q;
      exc_d   = exc_q;
      prd_d   = prd_q;
      wb_row  = '0;
      wb_bank = '0;
      for (int r = 0; r < SIZE; r++) begin
         for (int b = 0; b < NBANK; b++) begin
            brm_d[r][b] = brm_q[r][b] & ~i_br_clr;
         end
      end
      // Qualify on stored state so every port hitting one slot contributes its exc bit.
      for (int p = 0; p < NWB; p++) begin
         wb_bank = i_wb_tag[p*WIDTH_TAG +: WIDTH_BK];
         wb_row  = i_wb_tag[p*WIDTH_TAG + WIDTH_BK +: WIDTH_BANK];
         if (i_wb_en[p] && val_q[wb_row][wb_bank] && busy_q[wb_row][wb_bank]) begin
            busy_d[wb_row][wb_bank] = 1'b0;
            exc_d[wb_row][wb_bank]  = exc_d[wb_row][wb_bank] | i_wb_exc[p];
         end
      end
      if (com_en) begin
         val_d[head_q] = '0;
         head_d        = head_q + 1'b1;
      end
      if (dis_acc) begin
         val_d[tail_q]  = i_dis_val;
         busy_d[tail_q] = i_dis_val;
         exc_d[tail_q]  = '0;
         pc_d[tail_q]   = i_dis_pc[31:2];
         for (int b = 0; b < NBANK; b++) begin
            prd_d[tail_q][b] = i_dis_prd[b*WIDTH_REG +: WIDTH_REG];
            brm_d[tail_q][b] = i_dis_brmask[b*WIDTH_BRM +: WIDTH_BRM];
         end
         tail_d = tail_q + 1'b1;
      end
      if (i_kill_en) begin
         for (int r = 0; r < SIZE; r++) begin
            for (int b = 0; b < NBANK; b++) begin
               if ((brm_q[r][b] & i_kill_mask) != '0) begin
                  val_d[r][b]  = 1'b0;
                  busy_d[r][b] = 1'b0;
               end
            end
         end
         tail_d  = i_kill_row + 1'b1;
         // Rows head..kill_row survive; a same-cycle commit removes one of them.
         count_d = {1'b0, i_kill_row - head_q} + (WIDTH_BANK+1)'(1)
                   - (WIDTH_BANK+1)'(com_en);
      end else begin
         count_d = count_q + (WIDTH_BANK+1)'(dis_acc) - (WIDTH_BANK+1)'(com_en);
      end
      if (head_exc) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         for (int r = 0; r < SIZE; r++) begin
            val_d[r]  = '0;
            busy_d[r] = '0;
            exc_d[r]  = '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int r = 0; r < SIZE; r++) begin
            pc_q[r]   <= '0;
            val_q[r]  <= '0;
            busy_q[r] <= '0;
            exc_q[r]  <= '0;
            for (int b = 0; b < NBANK; b++) begin
               prd_q[r][b] <= '0;
               brm_q[r][b] <= '0;
            end
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         val_q   <= val_d;
         busy_q  <= busy_d;
         exc_q   <= exc_d;
         prd_q   <= prd_d;
         brm_q   <= brm_d;
      end
   end
endmodule
